// File: rtl/multisim_pull_arbiter.sv
// -----------------------------------------------------------------------------
// multisim_pull_arbiter
//
// Shares one multisim pull channel (valid/ready source) between NUM_PORTS
// local consumers. A round-robin pointer selects the next requester, one word
// is pulled from the channel and handed to exactly that consumer. When the
// channel reports no data, the arbiter waits BACKOFF_CYCLES before polling
// again so the channel is not hammered with empty polls.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   up_data_vld   channel word valid
//   up_data_rdy   arbiter accepts channel word (high only while fetching)
//   up_data       channel payload
//   req           per-consumer request
//   dn_data_vld   one-hot word valid toward the granted consumer
//   dn_data_rdy   per-consumer accept (only the granted bit is looked at)
//   dn_data       shared payload bus, meaningful where dn_data_vld is set
//   grant_idx     currently granted consumer
//   busy          arbiter is not idle
// -----------------------------------------------------------------------------
module multisim_pull_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_PORTS      = 4,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         up_data_vld,
  output logic                         up_data_rdy,
  input  logic [DATA_WIDTH-1:0]        up_data,
  input  logic [NUM_PORTS-1:0]         req,
  output logic [NUM_PORTS-1:0]         dn_data_vld,
  input  logic [NUM_PORTS-1:0]         dn_data_rdy,
  output logic [DATA_WIDTH-1:0]        dn_data,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  // Counter must hold BACKOFF_CYCLES itself and never collapse to zero width.
  localparam int CNT_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BACKOFF_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DELIVER,
    S_BACKOFF
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_grant;
  logic [IDX_W-1:0]      w_grant_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [IDX_W-1:0]      w_grant_inc;
  logic [IDX_W-1:0]      w_rr_idx;
  logic                  w_rr_found;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_capture;

  // Rotating-priority search: first set req bit at or after the pointer.
  always_comb begin
    int cand;
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    cand       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (int'(r_ptr) + i) % NUM_PORTS;
      if (!w_rr_found && req[IDX_W'(cand)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IDX_W'(cand);
      end
    end
  end

  // Pointer moves just past whoever was served or gave up, wrapping at the top.
  assign w_grant_inc = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    up_data_rdy = 1'b0;
    dn_data_vld = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rr_found) begin
          w_grant_nxt = w_rr_idx;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        up_data_rdy = 1'b1;
        if (up_data_vld) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DELIVER;
        end else if (BACKOFF_CYCLES == 0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        // A withdrawn request wins over expiry; the grant is given up and the
        // next consumer in line gets the first shot.
        if (!req[r_grant]) begin
          w_ptr_nxt   = w_grant_inc;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_FETCH;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DELIVER: begin
        // Held until the granted consumer takes it, even if its req drops.
        dn_data_vld[r_grant] = 1'b1;
        if (dn_data_rdy[r_grant]) begin
          w_ptr_nxt   = w_grant_inc;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset branch clears state immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_data <= up_data;
      end
    end
  end

  assign dn_data   = r_data;
  assign grant_idx = r_grant;
  assign busy      = (r_state != S_IDLE);

  a_vld_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(dn_data_vld));

  a_rdy_only_fetch : assert property (@(posedge clk) disable iff (!rst_n)
    up_data_rdy |-> (r_state == S_FETCH));

  a_data_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (|(dn_data_vld & ~dn_data_rdy)) |=> $stable(dn_data));

endmodule

// File: tb/tb_multisim_pull_arbiter.sv
// -----------------------------------------------------------------------------
// tb_multisim_pull_arbiter
//
// Directed bench for multisim_pull_arbiter (64-bit, 4 ports, backoff 16).
// An upstream driver serves words from up_q; each scenario pushes the
// deliveries it expects into exp_q, and a monitor pops and compares on every
// downstream handshake. Timing-specific points are checked inline.
// -----------------------------------------------------------------------------
module tb_multisim_pull_arbiter;

  localparam int DW = 64;
  localparam int NP = 4;
  localparam int BC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_data_vld = 1'b0;
  logic          up_data_rdy;
  logic [DW-1:0] up_data = '0;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] dn_data_vld;
  logic [NP-1:0] dn_data_rdy = '0;
  logic [DW-1:0] dn_data;
  logic [1:0]    grant_idx;
  logic          busy;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] up_q[$];
  bit            up_en = 1'b0;
  int            hs_cyc[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  multisim_pull_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_PORTS     (NP),
    .BACKOFF_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_data_vld(up_data_vld),
    .up_data_rdy(up_data_rdy),
    .up_data    (up_data),
    .req        (req),
    .dn_data_vld(dn_data_vld),
    .dn_data_rdy(dn_data_rdy),
    .dn_data    (dn_data),
    .grant_idx  (grant_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_word(input int port, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_sb(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    dn_data_rdy = '0;
    up_en = 1'b0;
    up_q.delete();
    exp_q.delete();
    hs_cyc.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Upstream channel model: word at the head of up_q is offered while up_en.
  initial begin : up_driver
    bit hs;
    forever begin
      @(negedge clk);
      hs = rst_n && up_data_vld && up_data_rdy;
      @(posedge clk);
      #1;
      if (hs && up_q.size() > 0) void'(up_q.pop_front());
      up_data_vld = up_en && (up_q.size() > 0);
      up_data     = (up_q.size() > 0) ? up_q[0] : '0;
    end
  end

  // Scoreboard monitor: a handshake seen here completes on the next rising edge.
  initial begin : monitor
    logic [NP-1:0] hsv;
    int            p;
    exp_t          e;
    forever begin
      @(negedge clk);
      hsv = dn_data_vld & dn_data_rdy;
      if (rst_n && hsv != '0) begin
        hs_cyc.push_back(cyc);
        p = -1;
        for (int k = 0; k < NP; k++) if (hsv[k]) p = k;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: port %0d got 0x%0h, nothing expected", p, dn_data);
        end else begin
          e = exp_q.pop_front();
          check("dn_port", p, e.port);
          check("dn_data", dn_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w;
    int rdy_pos[$];
    int exp_pos[4];
    int up_hs_i;
    int dn_i;

    // Reset values
    tick();
    check("rst_up_rdy", up_data_rdy, 0);
    check("rst_dn_vld", dn_data_vld, 0);
    check("rst_dn_data", dn_data, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_busy", busy, 0);

    // Single requester, always-valid channel: words in order, period 3
    do_reset();
    up_q.push_back(64'hA0); up_q.push_back(64'hA1); up_q.push_back(64'hA2);
    expect_word(0, 64'hA0); expect_word(0, 64'hA1); expect_word(0, 64'hA2);
    dn_data_rdy = '1;
    up_en = 1'b1;
    req = 4'b0001;
    wait_sb(60, "t1_drain");
    check("t1_count", hs_cyc.size(), 3);
    if (hs_cyc.size() >= 3) begin
      check("t1_period_a", hs_cyc[1] - hs_cyc[0], 3);
      check("t1_period_b", hs_cyc[2] - hs_cyc[1], 3);
    end

    // All requesters: round robin 0,1,2,3,0,1,2,3 with words 0..7
    do_reset();
    for (int i = 0; i < 8; i++) begin
      up_q.push_back(DW'(i));
      expect_word(i % NP, DW'(i));
    end
    dn_data_rdy = '1;
    up_en = 1'b1;
    req = 4'b1111;
    wait_sb(100, "t2_drain");

    // Empty channel: one poll per 17 cycles, late word taken at the next poll
    do_reset();
    dn_data_rdy = '1;
    req = 4'b0001;
    up_hs_i = -1;
    dn_i = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (up_data_rdy) rdy_pos.push_back(i);
      if (up_data_vld && up_data_rdy && up_hs_i < 0) up_hs_i = i;
      if (dn_data_vld[0] && dn_i < 0) dn_i = i;
      if (i == 44) begin
        up_q.push_back(64'hC3);
        expect_word(0, 64'hC3);
        up_en = 1'b1;
      end
      if (i == 53) req = '0;
    end
    exp_pos = '{1, 18, 35, 52};
    check("t3_poll_count", rdy_pos.size(), 4);
    for (int k = 0; k < 4 && k < rdy_pos.size(); k++) check("t3_poll_cycle", rdy_pos[k], exp_pos[k]);
    check("t3_up_hs_cycle", up_hs_i, 52);
    check("t3_dn_vld_cycle", dn_i, 53);
    check("t3_delivered", exp_q.size(), 0);

    // Consumer stall on port 2: word held, channel not polled
    do_reset();
    up_q.push_back(64'h55); up_q.push_back(64'h66);
    expect_word(2, 64'h55); expect_word(2, 64'h66);
    dn_data_rdy = 4'b1011;
    req = 4'b0100;
    up_en = 1'b1;
    w = 0;
    while (!dn_data_vld[2] && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("t4_vld_seen", dn_data_vld, 4'b0100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_data", dn_data, 64'h55);
      check("t4_hold_vld", dn_data_vld, 4'b0100);
      check("t4_up_rdy_low", up_data_rdy, 0);
    end
    tick();
    dn_data_rdy = 4'b1111;
    wait_sb(60, "t4_drain");

    // Request withdrawal in backoff: port 1 gives up, port 3 granted next
    do_reset();
    dn_data_rdy = '1;
    req = 4'b0010;
    w = 0;
    while (!up_data_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("t5_fetch_seen", up_data_rdy, 1);
    tick();
    tick();
    @(negedge clk);
    check("t5_backoff_grant", grant_idx, 1);
    check("t5_backoff_busy", busy, 1);
    check("t5_backoff_rdy", up_data_rdy, 0);
    tick();
    req = 4'b1000;
    up_q.push_back(64'h77);
    expect_word(3, 64'h77);
    up_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_idle_busy", busy, 0);
    @(negedge clk);
    check("t5_new_grant", grant_idx, 3);
    check("t5_new_fetch", up_data_rdy, 1);
    wait_sb(40, "t5_drain");

    // Reset mid-DELIVER: outputs clear at once, arbitration restarts at port 0
    do_reset();
    dn_data_rdy = 4'b0010;
    req = 4'b0010;
    up_q.push_back(64'h98); up_q.push_back(64'h99);
    expect_word(1, 64'h98);
    up_en = 1'b1;
    wait_sb(30, "t6_first");
    tick();
    dn_data_rdy = '0;
    w = 0;
    while (!dn_data_vld[1] && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("t6_deliver_vld", dn_data_vld, 4'b0010);
    check("t6_deliver_data", dn_data, 64'h99);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_up_rdy", up_data_rdy, 0);
    check("t6_rst_dn_vld", dn_data_vld, 0);
    check("t6_rst_dn_data", dn_data, 0);
    check("t6_rst_grant", grant_idx, 0);
    check("t6_rst_busy", busy, 0);
    req = 4'b1111;
    dn_data_rdy = '1;
    up_q.delete();
    exp_q.delete();
    up_q.push_back(64'hB0);
    expect_word(0, 64'hB0);
    up_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_restart_grant", grant_idx, 0);
    check("t6_restart_fetch", up_data_rdy, 1);
    wait_sb(40, "t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
